cordic_mul_scheduler: RTL and testbench

CORDIC_MUL_SCHEDULER -- requirements
Module: cordic_mul_scheduler

---
 rtl/cordic_sched_pkg.sv | 21 ++
 rtl/cordic_rr_arbiter.sv | 26 ++
 rtl/cordic_mul_scheduler.sv | 148 ++++++++++++++
 tb/tb_cordic_mul_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types and sizing for the CORDIC multiplier scheduler.
package cordic_sched_pkg;

  // Operand and product widths of the external multiplier.
  localparam int OP_W  = 8;
  localparam int RES_W = 16;

  // Default build configuration.
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 64;

  // Scheduler control states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at i_ptr and wraps,
// returning a one-hot grant (all zero when nobody requests).
module cordic_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [PTR_W-1:0] w_idx;

  // Walk the requesters starting at the pointer and take the first one found.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PTR_W'((int'(i_ptr) + k) % N);
      if ((o_grant == '0) && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_mul_scheduler.sv
// Shares one external CORDIC multiplier among NUM_REQ requesters.
// One operation is in flight at a time; a stuck multiplier is abandoned
// after TIMEOUT cycles and answered with rsp_err.
module cordic_mul_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OP_W-1:0]   req_x,
  input  logic [NUM_REQ*OP_W-1:0]   req_z,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic signed [RES_W-1:0]   rsp_y,
  output logic                      rsp_err,
  output logic                      mul_start,
  output logic signed [OP_W-1:0]    mul_x,
  output logic signed [OP_W-1:0]    mul_z,
  input  logic signed [RES_W-1:0]   mul_y,
  input  logic                      mul_done
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_gnt_idx;
  logic [PTR_W-1:0]        w_gnt_idx;
  logic [PTR_W-1:0]        w_ptr_next;
  logic [NUM_REQ-1:0]      w_grant;
  logic [OP_W-1:0]         w_sel_x;
  logic [OP_W-1:0]         w_sel_z;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [RES_W-1:0] r_rsp_y;
  logic                    r_rsp_err;
  logic signed [OP_W-1:0]  r_mul_x;
  logic signed [OP_W-1:0]  r_mul_z;
  logic                    w_accept;
  logic                    w_timeout;
  logic                    w_rsp_take;

  cordic_rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Convert the one-hot grant into an index and select that requester's operands.
  always_comb begin
    w_gnt_idx = '0;
    w_sel_x   = '0;
    w_sel_z   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_gnt_idx = PTR_W'(k);
        w_sel_x   = req_x[k*OP_W +: OP_W];
        w_sel_z   = req_z[k*OP_W +: OP_W];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
  assign w_accept   = (r_state == S_IDLE) && (|req_valid);
  // The counter reads 0 during ISSUE and counts cycles since the start pulse.
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rsp_take = rsp_ready[r_gnt_idx];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; mul_done has priority over the timeout in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|req_valid) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (mul_done || w_timeout) w_state_next = S_RESP;
      S_RESP:  if (w_rsp_take) w_state_next = S_DRAIN;
      // A level-style done must fall before the next operation may start.
      S_DRAIN: if (!mul_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs; req_ready is masked while reset is held.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (r_state)
      S_IDLE:  if (rst_n) req_ready = w_grant;
      S_ISSUE: mul_start = 1'b1;
      S_RESP:  rsp_valid[r_gnt_idx] = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, grant bookkeeping, timeout counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_cnt     <= '0;
      r_rsp_y   <= '0;
      r_rsp_err <= 1'b0;
      r_mul_x   <= '0;
      r_mul_z   <= '0;
    end else begin
      if (w_accept) begin
        r_mul_x   <= w_sel_x;
        r_mul_z   <= w_sel_z;
        r_gnt_idx <= w_gnt_idx;
        r_ptr     <= w_ptr_next;
        r_cnt     <= '0;
      end
      if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == S_WAIT) begin
        if (mul_done) begin
          r_rsp_y   <= mul_y;
          r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
          r_rsp_y   <= '0;
          r_rsp_err <= 1'b1;
        end
      end
    end
  end

  assign rsp_y   = r_rsp_y;
  assign rsp_err = r_rsp_err;
  assign mul_x   = r_mul_x;
  assign mul_z   = r_mul_z;

endmodule

// File: tb/tb_cordic_mul_scheduler.sv
// Bench for cordic_mul_scheduler with a behavioural multiplier model and a
// scoreboard of expected responses.
module tb_cordic_mul_scheduler;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int LAT = 10;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*8-1:0]     req_x;
  logic [N*8-1:0]     req_z;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic signed [15:0] rsp_y;
  logic               rsp_err;
  logic               mul_start;
  logic signed [7:0]  mul_x;
  logic signed [7:0]  mul_z;
  logic signed [15:0] mul_y;
  logic               mul_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int                 idx;
    logic signed [15:0] y;
    logic               err;
  } exp_t;
  exp_t sb[$];

  cordic_mul_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_z     (req_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_z     (mul_z),
    .mul_y     (mul_y),
    .mul_done  (mul_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier model: done rises LAT cycles after the start cycle and stays
  // high for m_len cycles; m_never suppresses done entirely.
  int cyc = 0;
  int m_at = 0;
  bit m_active = 1'b0;
  int m_len = 1;
  bit m_never = 1'b0;
  int start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_active <= 1'b0;
      mul_done <= 1'b0;
      mul_y    <= '0;
    end else begin
      if (mul_start) begin
        start_cnt <= start_cnt + 1;
        mul_y     <= mul_x * mul_z;
        if (!m_never) begin
          m_active <= 1'b1;
          m_at     <= cyc + LAT;
        end
      end
      mul_done <= m_active && (cyc + 1 >= m_at) && (cyc + 1 < m_at + m_len);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input int i, input int x, input int z);
    req_x[i*8 +: 8] = 8'(x);
    req_z[i*8 +: 8] = 8'(z);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Waits (bounded) for a cycle where some requester is being accepted.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if ((req_ready & req_valid) != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits (bounded) for rsp_valid; n is the number of negedges taken.
  task automatic wait_rsp(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        n = i;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = '0;
    set_op(0, 1, 1);
    repeat (2) @(negedge clk);
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    total++; if (rsp_y !== 16'sd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp: got y=%0d err=%b want 0/0", rsp_y, rsp_err); end
    total++; if (mul_start !== 1'b0 || mul_x !== 8'sd0 || mul_z !== 8'sd0) begin bad++; $display("FAIL reset_mul: got start=%b x=%0d z=%0d want 0", mul_start, mul_x, mul_z); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    bit ok; int n; exp_t e;
    do_reset();
    set_op(0, 7, -3);
    req_valid = 4'b0001;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    sb.push_back('{0, 16'(7 * -3), 1'b0});
    @(negedge clk);
    req_valid = '0;
    total++; if (mul_start !== 1'b1 || mul_x !== 8'sd7 || mul_z !== -8'sd3) begin bad++; $display("FAIL single_issue: got start=%b x=%0d z=%0d want 1/7/-3", mul_start, mul_x, mul_z); end
    wait_rsp(n, ok);
    total++; if (!ok || n + 1 != LAT + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", n + 1, LAT + 2); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y || rsp_err !== e.err) begin bad++; $display("FAIL single_rsp: got v=%b y=%0d err=%b want v=%b y=%0d err=%b", rsp_valid, rsp_y, rsp_err, 4'(1 << e.idx), e.y, e.err); end
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL single_release: got %b want 0000", rsp_valid); end
    $display("test_single done: latency=%0d", n + 1);
  endtask

  task automatic test_round_robin();
    bit ok; int n; exp_t e;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_accept(ok);
      total++; if (!ok || req_ready !== 4'(1 << (k % N))) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % N))); end
      sb.push_back('{k % N, 16'(((k % N) + 1) * 10), 1'b0});
      wait_rsp(n, ok);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y || rsp_err !== e.err) begin bad++; $display("FAIL rr_rsp%0d: got v=%b y=%0d err=%b want v=%b y=%0d", k, rsp_valid, rsp_y, rsp_err, 4'(1 << e.idx), e.y); end
      end
      $display("test_rr op %0d: grant=%0d y=%0d", k, e.idx, rsp_y);
    end
    req_valid = '0;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_timeout();
    bit ok; int n; exp_t e;
    do_reset();
    m_never = 1'b1;
    set_op(2, 5, 5);
    req_valid = 4'b0100;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0100) begin bad++; $display("FAIL to_grant: got %b want 0100", req_ready); end
    sb.push_back('{2, 16'sd0, 1'b1});
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n, ok);
    total++; if (!ok || n != TO) begin bad++; $display("FAIL to_latency_after_issue: got %0d want %0d", n, TO); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y || rsp_err !== e.err) begin bad++; $display("FAIL to_rsp: got v=%b y=%0d err=%b want v=%b y=%0d err=%b", rsp_valid, rsp_y, rsp_err, 4'(1 << e.idx), e.y, e.err); end
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
    m_never = 1'b0;
    $display("test_timeout done: cycles_after_issue=%0d", n);
  endtask

  task automatic test_backpressure();
    bit ok; int n; int s0; logic signed [15:0] y0; exp_t e;
    do_reset();
    set_op(3, -4, 9);
    req_valid = 4'b1000;
    wait_accept(ok);
    sb.push_back('{3, 16'(-4 * 9), 1'b0});
    @(negedge clk);
    set_op(0, 11, 12);
    req_valid = 4'b0001;
    wait_rsp(n, ok);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y) begin bad++; $display("FAIL bp_rsp: got v=%b y=%0d want v=%b y=%0d", rsp_valid, rsp_y, 4'(1 << e.idx), e.y); end
    end
    s0 = start_cnt;
    y0 = rsp_y;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 4'b1000 || rsp_y !== y0 || req_ready !== 4'h0) begin bad++; $display("FAIL bp_hold%0d: got v=%b y=%0d rdy=%b want 1000/%0d/0000", i, rsp_valid, rsp_y, req_ready, y0); end
    end
    total++; if (start_cnt != s0) begin bad++; $display("FAIL bp_no_start: got %0d starts want %0d", start_cnt, s0); end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = '0;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
    sb.push_back('{0, 16'(11 * 12), 1'b0});
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n, ok);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y) begin bad++; $display("FAIL bp_rsp2: got v=%b y=%0d want v=%b y=%0d", rsp_valid, rsp_y, 4'(1 << e.idx), e.y); end
    end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    $display("test_backpressure done: held y=%0d", y0);
  endtask

  task automatic test_level_done();
    bit ok; int n; int extra; int st; exp_t e;
    do_reset();
    m_len = 3;
    rsp_ready = 4'hF;
    set_op(1, 3, -5);
    req_valid = 4'b0010;
    wait_accept(ok);
    sb.push_back('{1, 16'(3 * -5), 1'b0});
    @(negedge clk);
    wait_rsp(n, ok);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y) begin bad++; $display("FAIL lvl_rsp: got v=%b y=%0d want v=%b y=%0d", rsp_valid, rsp_y, 4'(1 << e.idx), e.y); end
    end
    extra = 0;
    st = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) extra++;
      if (mul_start && st == 0) begin
        st = i;
        sb.push_back('{1, 16'(3 * -5), 1'b0});
      end
    end
    req_valid = '0;
    total++; if (extra != 0) begin bad++; $display("FAIL lvl_single_rsp: got %0d extra responses want 0", extra); end
    total++; if (st != 4) begin bad++; $display("FAIL lvl_next_start: got %0d cycles after rsp want 4", st); end
    wait_rsp(n, ok);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y) begin bad++; $display("FAIL lvl_rsp2: got v=%b y=%0d want v=%b y=%0d", rsp_valid, rsp_y, 4'(1 << e.idx), e.y); end
    end
    @(negedge clk);
    rsp_ready = '0;
    m_len = 1;
    $display("test_level_done done: next_start=%0d", st);
  endtask

  task automatic test_reset_mid_op();
    bit ok; int n; int spurious; exp_t e;
    do_reset();
    set_op(2, 6, 6);
    req_valid = 4'b0100;
    wait_accept(ok);
    sb.push_back('{2, 16'sd36, 1'b0});
    @(negedge clk);
    req_valid = 4'hF;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++; if (rsp_valid !== 4'h0 || req_ready !== 4'h0 || mul_start !== 1'b0) begin bad++; $display("FAIL mid_reset_ctrl: got v=%b rdy=%b start=%b want 0", rsp_valid, req_ready, mul_start); end
    total++; if (mul_x !== 8'sd0 || mul_z !== 8'sd0 || rsp_y !== 16'sd0 || rsp_err !== 1'b0) begin bad++; $display("FAIL mid_reset_data: got x=%0d z=%0d y=%0d err=%b want 0", mul_x, mul_z, rsp_y, rsp_err); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL mid_no_stale_rsp: got %0d responses want 0", spurious); end
    set_op(1, -128, -128);
    set_op(3, 1, 1);
    req_valid = 4'b1010;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0010) begin bad++; $display("FAIL mid_first_grant: got %b want 0010", req_ready); end
    sb.push_back('{1, 16'(-128 * -128), 1'b0});
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n, ok);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (!ok || rsp_valid !== 4'(1 << e.idx) || rsp_y !== e.y || rsp_err !== e.err) begin bad++; $display("FAIL mid_rsp: got v=%b y=%0d err=%b want v=%b y=%0d", rsp_valid, rsp_y, rsp_err, 4'(1 << e.idx), e.y); end
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    $display("test_reset_mid_op done: y=%0d", rsp_y);
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = '0;
    req_x = '0;
    req_z = '0;
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_level_done();
    test_reset_mid_op();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
